tmr_error_monitor: RTL and testbench
====================================

// Module: tmr_error_monitor
// PURPOSE
//   Sits downstream of the TMR word voters and consumes their 3-bit ERROR vector (bit i = replica i outvoted).
//   Classifies each disagreement as transient or persistent.
//   - Transient: issues a resync req/ack handshake naming the replica to rescrub.
//   - Persistent: flags the replica as failed (sticky).
//   - Multi-replica disagreement: raises sticky fatal.
// PARAMETERS
//   PERSIST_CYC     4   consecutive flagged cycles that declare a replica failed (legal >=2)
//   RESYNC_TIMEOUT  64  cycles resync_req may wait for resync_ack before giving up (legal >=2)
//   CNT_W           16  width of each stats counter (TMR_MON_STATS_EN only)
// PORTS
//   clk             in   1        clock
//   resetn          in   1        asynchronous, active-low reset
//   err_in          in   3        voter ERROR vector; OR of several voters allowed
//   clr             in   1        sync clear of sticky flags and FSM
//   resync_req      out  1        request rescrub of replica resync_rep
//   resync_rep      out  2        replica index 0..2; stable while resync_req=1
//   resync_ack      in   1        consumer accepts request (sampled when resync_req=1)
//   replica_failed  out  3        sticky, per replica
//   fatal           out  1        sticky, uncorrectable condition
//   timeout         out  1        1-cycle pulse, resync not acknowledged in time
// BEHAVIOUR
//   Reset: every output 0, err_q=0, state IDLE, run_cnt=0, timer=0.
//   Input register: err_q <= err_in & ~replica_failed. Failed replicas are masked from classification.
//   FSM IDLE -> CONFIRM -> REQ -> IDLE.
//   IDLE
//     - popcount(err_q)==1 -> rep <= index, run_cnt <= 1, go CONFIRM.
//   CONFIRM
//     - err_q == onehot(rep) -> run_cnt++. When run_cnt reaches PERSIST_CYC -> replica_failed[rep] <= 1, go IDLE.
//     - err_q == 0 -> transient, go REQ.
//     - err_q == a different single replica -> rep <= new index, run_cnt <= 1, stay CONFIRM.
//   REQ
//     - resync_req=1, resync_rep=rep, timer counts from 0.
//     - resync_ack=1 -> go IDLE, timer <= 0.
//     - timer == RESYNC_TIMEOUT-1 without ack -> timeout pulse, replica_failed[rep] <= 1, go IDLE.
//     - err_q changes are ignored in REQ, except for fatal.
//   fatal <= 1 in any state when popcount(err_q)>=2 or popcount(replica_failed)>=2.
//     The FSM keeps running after fatal.
//   Latency
//     - Single-cycle err_in pulse in cycle t -> resync_req=1 from cycle t+3.
//     - err_in held from t -> replica_failed visible in cycle t+PERSIST_CYC+1.
//   Priorities (same cycle)
//     - clr > resync_ack > timeout.
//     - clr forces IDLE, drops resync_req, clears replica_failed, fatal, run_cnt and timer.
//     - clr does not clear err_q.
//   resetn asserted mid-handshake drops resync_req asynchronously. No ack is expected afterwards.
//   run_cnt saturates at PERSIST_CYC and never wraps. Timer width = $clog2(RESYNC_TIMEOUT).
// CONFIGURATION
//   TMR_MON_STATS_EN defined
//     - Adds ports stat_clr (in, 1) and stat_cnt (out, 3*CNT_W; replica i at [i*CNT_W +: CNT_W]).
//     - stat_cnt[i] increments on every cycle err_in[i]=1 (unmasked, before err_q).
//     - Counters saturate at all-ones and reset to 0.
//     - stat_clr zeroes all counters synchronously and wins over increment.
//     - clr does not affect the counters.
//   TMR_MON_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   Package tmr_pkg
//     - typedef enum logic [1:0] {IDLE, CONFIRM, REQ} tmr_mon_state_t
//     - localparam TMR_REPLICAS = 3
//     - function popcount3(logic [2:0]) returning logic [1:0]
//   Sub-module tmr_sat_counter #(W)
//     - inputs inc and clr; saturating up-counter with async active-low reset
//     - used 3x for stats and 1x for the REQ timer (clr = leaving REQ)
// TESTING
//   err_in=3'b010 for 1 cycle at t -> resync_req=1, resync_rep=1 at t+3; ack at t+5 -> req=0 at t+6, no flags.
//   err_in=3'b001 held 6 cycles -> replica_failed=3'b001 at t+5, no resync_req, later err_in[0] ignored.
//   Transient on replica 2, ack never given -> timeout pulse 1 cycle, replica_failed=3'b100, req dropped.
//   err_in=3'b011 one cycle in IDLE -> fatal=1 sticky; clr -> fatal=0, replica_failed=0, state IDLE.
//   resync_ack and clr together in REQ -> IDLE, flags cleared; resetn low in REQ -> req=0 at once.
//   STATS_EN: err_in[1] high 70000 cycles, CNT_W=16 -> stat_cnt[1]=16'hFFFF; stat_clr -> 0 next cycle.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR error monitor.
package tmr_pkg;

  typedef enum logic [1:0] {IDLE, CONFIRM, REQ} tmr_mon_state_t;

  localparam int TMR_REPLICAS = 3;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] onehot_index(input logic [2:0] v);
    if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else return 2'd0;
  endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module tmr_sat_counter
  import tmr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tmr_error_monitor.sv
// Classifies TMR voter disagreements as transient (resync handshake) or persistent (sticky fail).
// Optional per-replica error statistics are built when TMR_MON_STATS_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no single-replica disagreement under observation
// CONFIRM | one replica flagged; counting consecutive flagged cycles
// REQ     | transient seen; resync_req held until ack or timeout
module tmr_error_monitor
  import tmr_pkg::*;
#(
  parameter int PERSIST_CYC    = 4,
  parameter int RESYNC_TIMEOUT = 64,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [TMR_REPLICAS-1:0]     err_in,
  input  logic                        clr,
  output logic                        resync_req,
  output logic [1:0]                  resync_rep,
  input  logic                        resync_ack,
  output logic [TMR_REPLICAS-1:0]     replica_failed,
  output logic                        fatal,
  output logic                        timeout
`ifdef TMR_MON_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [TMR_REPLICAS*CNT_W-1:0] stat_cnt
`endif
);

  localparam int RUN_W = $clog2(PERSIST_CYC + 1);
  localparam int TMR_W = $clog2(RESYNC_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(PERSIST_CYC);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PERSIST_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESYNC_TIMEOUT - 1);

  if (PERSIST_CYC < 2 || RESYNC_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("tmr_error_monitor: illegal parameter value");
  end

  tmr_mon_state_t state_q, state_d;
  logic [2:0]       err_q, err_d, err_m;
  logic [2:0]       failed_q, failed_d;
  logic [1:0]       rep_q, rep_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             fatal_q, fatal_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       err_pop;
  logic [TMR_W-1:0] timer;
  logic             in_req;
  logic             timer_clr;

  assign err_d   = err_in & ~failed_q;
  // Re-mask with the current flags so a replica failed on the same edge err_q
  // was loaded is not picked up again by IDLE.
  assign err_m   = err_q & ~failed_q;
  assign err_pop = popcount3(err_m);
  assign in_req  = (state_q == REQ);

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    run_d     = run_q;
    failed_d  = failed_q;
    fatal_d   = fatal_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (err_pop == 2'd1) begin
          rep_d   = onehot_index(err_m);
          run_d   = RUN_W'(1);
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (err_m == (3'b001 << rep_q)) begin
          if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
          if (run_q >= RUN_LAST) begin
            failed_d = failed_q | (3'b001 << rep_q);
            state_d  = IDLE;
          end
        end else if (err_m == 3'b000) begin
          state_d = REQ;
        end else if (err_pop == 2'd1) begin
          rep_d = onehot_index(err_m);
          run_d = RUN_W'(1);
        end else begin
          // Several replicas at once: fatal covers it, abandon this candidate.
          run_d   = '0;
          state_d = IDLE;
        end
      end
      REQ: begin
        if (resync_ack) begin
          state_d = IDLE;
        end else if (timer == TMR_LAST) begin
          timeout_d = 1'b1;
          failed_d  = failed_q | (3'b001 << rep_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((err_pop >= 2'd2) || (popcount3(failed_q) >= 2'd2)) fatal_d = 1'b1;

    if (clr) begin
      state_d   = IDLE;
      failed_d  = '0;
      fatal_d   = 1'b0;
      run_d     = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      err_q     <= '0;
      failed_q  <= '0;
      rep_q     <= '0;
      run_q     <= '0;
      fatal_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      failed_q  <= failed_d;
      rep_q     <= rep_d;
      run_q     <= run_d;
      fatal_q   <= fatal_d;
      timeout_q <= timeout_d;
    end
  end

  assign timer_clr = clr | (in_req & (state_d != REQ));

  tmr_sat_counter #(.W(TMR_W)) u_req_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (timer_clr),
    .inc    (in_req),
    .cnt    (timer)
  );

`ifdef TMR_MON_STATS_EN
  for (genvar i = 0; i < TMR_REPLICAS; i++) begin : g_stat
    tmr_sat_counter #(.W(CNT_W)) u_stat (
      .clk    (clk),
      .resetn (resetn),
      .clr    (stat_clr),
      .inc    (err_in[i]),
      .cnt    (stat_cnt[i*CNT_W +: CNT_W])
    );
  end
`endif

  assign resync_req     = in_req;
  assign resync_rep     = rep_q;
  assign replica_failed = failed_q;
  assign fatal          = fatal_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Self-checking bench for tmr_error_monitor: directed scenarios plus random traffic vs a reference model.
module tb_tmr_error_monitor;

  localparam int PERSIST = 4;
  localparam int TO      = 64;
  localparam int CNT_W   = 16;

  logic       clk;
  logic       resetn;
  logic [2:0] err_in;
  logic       clr;
  logic       resync_ack;
  logic       resync_req;
  logic [1:0] resync_rep;
  logic [2:0] replica_failed;
  logic       fatal;
  logic       timeout;
`ifdef TMR_MON_STATS_EN
  logic                 stat_clr;
  logic [3*CNT_W-1:0]   stat_cnt;
`endif

  tmr_error_monitor #(
    .PERSIST_CYC    (PERSIST),
    .RESYNC_TIMEOUT (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .err_in         (err_in),
    .clr            (clr),
    .resync_req     (resync_req),
    .resync_rep     (resync_rep),
    .resync_ack     (resync_ack),
    .replica_failed (replica_failed),
    .fatal          (fatal),
    .timeout        (timeout)
`ifdef TMR_MON_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_cnt       (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_run==0 means no candidate, otherwise length of the current flagged run.
  bit [2:0] m_err, m_failed;
  bit       m_fatal, m_timeout, m_req;
  int       m_rep, m_run, m_age;

  task automatic model_reset();
    m_err = 0; m_failed = 0; m_fatal = 0; m_timeout = 0; m_req = 0;
    m_rep = 0; m_run = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit [2:0] seen, nfail;
    int       n, idx;
    bit       nfat, nto;
    if (!resetn) begin
      model_reset();
      return;
    end
    seen  = m_err & ~m_failed;
    n     = $countones(seen);
    idx   = seen[2] ? 2 : (seen[1] ? 1 : 0);
    nfail = m_failed;
    nto   = 0;
    nfat  = m_fatal || (n >= 2) || ($countones(m_failed) >= 2);
    if (m_req) begin
      if (resync_ack) m_req = 0;
      else if (m_age == TO - 1) begin nto = 1; nfail[m_rep] = 1; m_req = 0; end
      else m_age++;
    end else if (m_run > 0) begin
      if (n == 1 && idx == m_rep) begin
        m_run++;
        if (m_run >= PERSIST) begin nfail[m_rep] = 1; m_run = 0; end
      end else if (n == 0) begin
        m_req = 1; m_age = 0; m_run = 0;
      end else if (n == 1) begin
        m_rep = idx; m_run = 1;
      end else begin
        m_run = 0;
      end
    end else if (n == 1) begin
      m_rep = idx; m_run = 1;
    end
    m_err = err_in & ~m_failed;
    if (clr) begin
      m_req = 0; m_run = 0; m_age = 0; nfail = 0; nfat = 0; nto = 0;
    end
    m_failed  = nfail;
    m_fatal   = nfat;
    m_timeout = nto;
  endtask

  task automatic compare_model();
    check("m_req", 32'(resync_req), 32'(m_req));
    if (m_req) check("m_rep", 32'(resync_rep), 32'(m_rep));
    check("m_failed", 32'(replica_failed), 32'(m_failed));
    check("m_fatal", 32'(fatal), 32'(m_fatal));
    check("m_timeout", 32'(timeout), 32'(m_timeout));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int       hold, ack_pct, r;
  bit [2:0] pat;
  int       sh;

  initial begin
    resetn = 1'b0; err_in = 3'b000; clr = 1'b0; resync_ack = 1'b0;
`ifdef TMR_MON_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(resync_req), 0);
    check("rst_failed", 32'(replica_failed), 0);
    check("rst_fatal", 32'(fatal), 0);
    check("rst_timeout", 32'(timeout), 0);
    resetn = 1'b1;
    ticks(2);

    // Transient on replica 1, acknowledged
    err_in = 3'b010; tick();
    err_in = 3'b000; check("tr_req_t1", 32'(resync_req), 0);
    tick(); check("tr_req_t2", 32'(resync_req), 0);
    tick(); check("tr_req_t3", 32'(resync_req), 1); check("tr_rep_t3", 32'(resync_rep), 1);
    tick(); check("tr_req_t4", 32'(resync_req), 1);
    tick(); resync_ack = 1'b1;
    tick(); resync_ack = 1'b0;
    check("tr_req_t6", 32'(resync_req), 0);
    check("tr_failed", 32'(replica_failed), 0);
    check("tr_timeout", 32'(timeout), 0);
    ticks(2);

    // Persistent on replica 0
    err_in = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("ps_nofail", 32'(replica_failed), 0);
      check("ps_noreq", 32'(resync_req), 0);
    end
    tick(); check("ps_failed_t5", 32'(replica_failed), 3'b001);
    tick(); err_in = 3'b000;
    ticks(3);
    err_in = 3'b001; tick(); err_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick(); check("ps_masked_noreq", 32'(resync_req), 0);
    end
    check("ps_fatal", 32'(fatal), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ps_clr_failed", 32'(replica_failed), 0);

    // Transient on replica 2, never acknowledged
    err_in = 3'b100; tick(); err_in = 3'b000;
    ticks(2); check("to_req_t3", 32'(resync_req), 1); check("to_rep_t3", 32'(resync_rep), 2);
    ticks(63); check("to_req_t66", 32'(resync_req), 1); check("to_pulse_t66", 32'(timeout), 0);
    tick();
    check("to_pulse_t67", 32'(timeout), 1);
    check("to_failed_t67", 32'(replica_failed), 3'b100);
    check("to_req_t67", 32'(resync_req), 0);
    tick(); check("to_pulse_t68", 32'(timeout), 0);
    clr = 1'b1; tick(); clr = 1'b0;

    // Two replicas at once
    err_in = 3'b011; tick(); err_in = 3'b000;
    check("ft_t1", 32'(fatal), 0);
    tick(); check("ft_t2", 32'(fatal), 1);
    ticks(4); check("ft_sticky", 32'(fatal), 1); check("ft_noreq", 32'(resync_req), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ft_clr_fatal", 32'(fatal), 0);
    check("ft_clr_failed", 32'(replica_failed), 0);

    // ack and clr together while requesting, with fatal set
    err_in = 3'b110; tick(); err_in = 3'b000; ticks(2);
    err_in = 3'b001; tick(); err_in = 3'b000; ticks(2);
    check("ac_req", 32'(resync_req), 1); check("ac_fatal", 32'(fatal), 1);
    resync_ack = 1'b1; clr = 1'b1; tick(); resync_ack = 1'b0; clr = 1'b0;
    check("ac_req_drop", 32'(resync_req), 0);
    check("ac_fatal_clr", 32'(fatal), 0);
    check("ac_timeout", 32'(timeout), 0);

    // Asynchronous reset in the middle of a request
    err_in = 3'b100; tick(); err_in = 3'b000; ticks(2);
    check("ar_req", 32'(resync_req), 1);
    resetn = 1'b0; #2;
    check("ar_req_async", 32'(resync_req), 0);
    check("ar_failed_async", 32'(replica_failed), 0);
    model_reset();
    tick(); resetn = 1'b1;
    ticks(2);

    // Random traffic
    hold = 0; ack_pct = 0; pat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        r = $urandom_range(3);
        ack_pct = (r == 0) ? 0 : (r == 1) ? 3 : (r == 2) ? 20 : 60;
      end
      if (hold == 0) begin
        r = $urandom_range(99);
        if (r < 50) pat = 3'b000;
        else if (r < 90) begin sh = $urandom_range(2); pat = 3'b001 << sh; end
        else begin
          r = $urandom_range(3);
          pat = (r == 0) ? 3'b011 : (r == 1) ? 3'b101 : (r == 2) ? 3'b110 : 3'b111;
        end
        hold = $urandom_range(1, 7);
      end
      err_in = pat;
      hold--;
      resync_ack = ($urandom_range(99) < ack_pct);
      clr = ($urandom_range(249) == 0);
      tick();
    end
    err_in = 3'b000; resync_ack = 1'b0; clr = 1'b0;

`ifdef TMR_MON_STATS_EN
    clr = 1'b1; stat_clr = 1'b1; tick(); clr = 1'b0; stat_clr = 1'b0;
    err_in = 3'b010;
    ticks(70000);
    err_in = 3'b000;
    tick();
    check("st_sat", 32'(stat_cnt[1*CNT_W +: CNT_W]), 32'hFFFF);
    check("st_idle0", 32'(stat_cnt[0*CNT_W +: CNT_W]), 0);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    check("st_clr", 32'(stat_cnt[1*CNT_W +: CNT_W]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
